// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - register-array memory with a host write port and a wrapping stream read engine
module mem_stream_reader #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  nxt_ptr;
  logic [CNT_W-1:0]   remaining;
  logic               err_q;
  logic               addr_bad;
  logic               wr_ok;
  logic               last_beat;

  assign addr_bad  = {1'b0, start_addr} >= (ADDR_W+1)'(DEPTH);
  assign wr_ok     = {1'b0, wr_addr} < (ADDR_W+1)'(DEPTH);
  assign nxt_ptr   = (rd_ptr == ADDR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
  assign last_beat = (remaining == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (count == '0 || addr_bad) state_nxt = FINISH;
          else                         state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (out_ready && last_beat) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == STREAM);
    out_last  = out_valid && last_beat;
    done      = (state == FINISH);
    err       = done && err_q;
  end

  // Nonblocking reads here see the pre-edge array, so a colliding write returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
      out_data  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
      case (state)
        IDLE: begin
          if (start) begin
            err_q     <= (count != '0) && addr_bad;
            rd_ptr    <= start_addr;
            remaining <= count;
            if (!addr_bad) out_data <= mem[start_addr];
          end
        end
        STREAM: begin
          if (out_ready) begin
            remaining <= remaining - 1'b1;
            if (!last_beat) begin
              rd_ptr   <= nxt_ptr;
              out_data <= mem[nxt_ptr];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
